instruction_fetch_decode: RTL and testbench

Front end of the sequential processing unit. It fetches one 32-bit instruction word from instruction memory over a req/ack handshake and splits it into the decoded fields (type, opc, rs, rt, rd, funct, shamt, imm, iindex). It hands those fields and the pc to the execution stage over a valid/ready handshake. It then waits for the execution stage to return nextpc before starting the next fetch, so only one instruction is in flight at a time.

---
 rtl/instruction_fetch_decode_pkg.sv | 53 +++++
 rtl/instruction_fetch_decode_if.sv | 56 +++++
 rtl/instruction_fetch_decode_field_decode.sv | 31 +++
 rtl/instruction_fetch_decode.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_decode.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_decode_pkg.sv
// ---------------------------------------------------------------------------
// spu_pkg
// Shared definitions for the sequential processing unit front end.
// Contents:
//   - instruction type encodings (TYPE_*)
//   - primary opcode constants (OPC_*)
//   - fetch/decode FSM state encoding (state_t)
//   - packed decoded-field bundle (fields_t)
//   - classify_opc: opcode -> instruction type
// ---------------------------------------------------------------------------
package spu_pkg;

  localparam logic [1:0] TYPE_I   = 2'b00;
  localparam logic [1:0] TYPE_R   = 2'b01;
  localparam logic [1:0] TYPE_J   = 2'b10;
  localparam logic [1:0] TYPE_ILL = 2'b11;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_ISSUE   = 2'd2,
    S_WAIT_PC = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]  itype;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] iindex;
  } fields_t;

  // Opcodes 010000..011111 share the prefix 01 in the top two bits,
  // so the illegal range reduces to a two-bit compare.
  function automatic logic [1:0] classify_opc(input logic [5:0] opc);
    logic [1:0] t;
    if (opc == OPC_SPECIAL)                    t = TYPE_R;
    else if (opc == OPC_J || opc == OPC_JAL)   t = TYPE_J;
    else if (opc[5:4] == 2'b01)                t = TYPE_ILL;
    else                                       t = TYPE_I;
    return t;
  endfunction

endpackage

// File: rtl/instruction_fetch_decode_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_decode_if
// Bundles the instruction-memory handshake, the issue handshake towards the
// execution stage and the nextpc return path.
// Modports:
//   master - the fetch/decode unit (drives imem_req/addr, issue fields)
//   slave  - the environment (imem + execution stage)
// Signals:
//   imem_req/imem_addr/imem_ack/imem_rdata     instruction memory handshake
//   issue_valid/issue_ready/pc + decoded fields issue handshake
//   nextpc_in/nextpc_valid                     next pc returned by execution
// ---------------------------------------------------------------------------
interface instruction_fetch_decode_if #(
  parameter int PC_W = 8
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  logic            issue_valid;
  logic            issue_ready;
  logic [PC_W-1:0] pc;
  logic [1:0]      instr_type;
  logic [5:0]      opc;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      funct;
  logic [15:0]     imm;
  logic [25:0]     iindex;

  logic [PC_W-1:0] nextpc_in;
  logic            nextpc_valid;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output issue_valid, pc, instr_type, opc, rs, rt, rd, shamt, funct,
           imm, iindex,
    input  issue_ready,
    input  nextpc_in, nextpc_valid
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  issue_valid, pc, instr_type, opc, rs, rt, rd, shamt, funct,
           imm, iindex,
    output issue_ready,
    output nextpc_in, nextpc_valid
  );

endinterface

// File: rtl/instruction_fetch_decode_field_decode.sv
// ---------------------------------------------------------------------------
// instr_field_decode
// Purely combinational split of a 32-bit instruction word into all decoded
// fields plus the type classification. Every field is produced regardless
// of type; the consumer picks the ones it needs.
// Ports:
//   instr  in  32        raw instruction word
//   fields out fields_t  decoded bundle
// ---------------------------------------------------------------------------
module instr_field_decode
  import spu_pkg::*;
(
  input  logic [31:0] instr,
  output fields_t     fields
);

  // Straight bit slicing; only the type needs any real logic.
  always_comb begin
    fields        = '0;
    fields.itype  = classify_opc(instr[31:26]);
    fields.opc    = instr[31:26];
    fields.rs     = instr[25:21];
    fields.rt     = instr[20:16];
    fields.rd     = instr[15:11];
    fields.shamt  = instr[10:6];
    fields.funct  = instr[5:0];
    fields.imm    = instr[15:0];
    fields.iindex = instr[25:0];
  end

endmodule

// File: rtl/instruction_fetch_decode.sv
// ---------------------------------------------------------------------------
// instruction_fetch_decode
// Front end of the sequential processing unit. Fetches one instruction over
// the imem req/ack handshake, registers its decoded fields, issues them over
// valid/ready, then waits for the execution stage to return nextpc before
// the next fetch (one instruction in flight).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   run        level enable, honoured only in IDLE and at the WAIT_PC exit
//   bus        instruction_fetch_decode_if.master (imem, issue, nextpc)
//   fetch_err  sticky imem timeout flag, cleared by the next ack
//   retired    count of instructions whose nextpc was accepted (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch_decode
  import spu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  instruction_fetch_decode_if.master bus,
  output logic                      fetch_err,
  output logic [CNT_W-1:0]          retired
);

  localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          state;
  state_t          next_state;
  fields_t         dec_fields;
  fields_t         fields_q;
  logic [PC_W-1:0] pc_q;
  logic [TCW-1:0]  tcnt;
  logic            imem_req_c;
  logic            issue_valid_c;
  logic            ack_take;
  logic            nextpc_take;
  logic            timeout_hit;

  instr_field_decode u_decode (
    .instr  (bus.imem_rdata),
    .fields (dec_fields)
  );

  assign ack_take    = (state == S_FETCH) && bus.imem_ack;
  assign nextpc_take = (state == S_WAIT_PC) && bus.nextpc_valid;
  // The counter holds the number of missed edges so far; when it already
  // reads TIMEOUT-2 this edge is the (TIMEOUT-1)th miss, so the flag becomes
  // visible in the TIMEOUT-th fetch cycle. An ack on the same edge wins.
  assign timeout_hit = (state == S_FETCH) && !bus.imem_ack &&
                       (tcnt == TCW'(TIMEOUT - 2));

  // State register; reset parks in IDLE, which drops req/valid at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; run is only sampled in IDLE and on leaving WAIT_PC.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (run) next_state = S_FETCH;
      S_FETCH:   if (bus.imem_ack) next_state = S_ISSUE;
      S_ISSUE:   if (bus.issue_ready) next_state = S_WAIT_PC;
      S_WAIT_PC: if (bus.nextpc_valid) next_state = run ? S_FETCH : S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state so the async reset
  // removes them without waiting for a clock.
  always_comb begin
    imem_req_c    = 1'b0;
    issue_valid_c = 1'b0;
    unique case (state)
      S_FETCH: imem_req_c    = 1'b1;
      S_ISSUE: issue_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: decoded-field capture, pc, timeout counter, error, retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fields_q  <= '0;
      pc_q      <= '0;
      tcnt      <= '0;
      fetch_err <= 1'b0;
      retired   <= '0;
    end else begin
      if (ack_take) begin
        fields_q  <= dec_fields;
        fetch_err <= 1'b0;
        tcnt      <= '0;
      end else if (timeout_hit) begin
        fetch_err <= 1'b1;
        tcnt      <= '0;
      end else if (state == S_FETCH) begin
        tcnt <= tcnt + TCW'(1);
      end else begin
        tcnt <= '0;
      end

      if (nextpc_take) begin
        pc_q    <= bus.nextpc_in;
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign bus.imem_req    = imem_req_c;
  assign bus.imem_addr   = imem_req_c ? pc_q : '0;
  assign bus.issue_valid = issue_valid_c;
  assign bus.pc          = pc_q;
  assign bus.instr_type  = fields_q.itype;
  assign bus.opc         = fields_q.opc;
  assign bus.rs          = fields_q.rs;
  assign bus.rt          = fields_q.rt;
  assign bus.rd          = fields_q.rd;
  assign bus.shamt       = fields_q.shamt;
  assign bus.funct       = fields_q.funct;
  assign bus.imm         = fields_q.imm;
  assign bus.iindex      = fields_q.iindex;

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_decode
// Directed bench: a linear sequence of imem/issue/nextpc steps with
// hand-computed expectations, checked by immediate assertions on negedge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_decode;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic            clk;
  logic            rst;
  logic            run;
  logic            fetch_err;
  logic [CNT_W-1:0] retired;
  int              nAsserts;
  int              nFails;

  instruction_fetch_decode_if #(.PC_W(PC_W)) bus ();

  instruction_fetch_decode #(
    .PC_W    (PC_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bus       (bus.master),
    .fetch_err (fetch_err),
    .retired   (retired)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] word);
    bus.imem_ack   = ack;
    bus.imem_rdata = word;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle issue_ready pulse followed by a one-cycle nextpc strobe.
  task automatic retire(input logic [PC_W-1:0] npc);
    bus.issue_ready = 1'b1;
    tick(1);
    bus.issue_ready = 1'b0;
    bus.nextpc_valid = 1'b1;
    bus.nextpc_in    = npc;
    tick(1);
    bus.nextpc_valid = 1'b0;
  endtask

  // Linear directed sequence.
  initial begin
    nAsserts = 0;
    nFails   = 0;
    rst = 1'b1;
    run = 1'b0;
    applyStimulus(1'b0, 32'h0);
    bus.issue_ready  = 1'b0;
    bus.nextpc_valid = 1'b0;
    bus.nextpc_in    = '0;
    tick(2);

    checkOutput("rst_req",     32'(bus.imem_req),    32'h0);
    checkOutput("rst_valid",   32'(bus.issue_valid), 32'h0);
    checkOutput("rst_addr",    32'(bus.imem_addr),   32'h0);
    checkOutput("rst_pc",      32'(bus.pc),          32'h0);
    checkOutput("rst_opc",     32'(bus.opc),         32'h0);
    checkOutput("rst_err",     32'(fetch_err),       32'h0);
    checkOutput("rst_retired", 32'(retired),         32'h0);

    rst = 1'b0;
    tick(1);
    checkOutput("idle_no_run_req", 32'(bus.imem_req), 32'h0);

    // Instruction A: ADDIU, ack two cycles after req.
    run = 1'b1;
    tick(1);
    checkOutput("a_req",   32'(bus.imem_req),    32'h1);
    checkOutput("a_addr",  32'(bus.imem_addr),   32'h0);
    checkOutput("a_valid_early", 32'(bus.issue_valid), 32'h0);
    tick(1);
    applyStimulus(1'b1, 32'h24220005);
    tick(1);
    applyStimulus(1'b0, 32'hDEADBEEF);
    checkOutput("a_valid", 32'(bus.issue_valid), 32'h1);
    checkOutput("a_req_off", 32'(bus.imem_req),  32'h0);
    checkOutput("a_type",  32'(bus.instr_type),  32'h0);
    checkOutput("a_opc",   32'(bus.opc),         32'h09);
    checkOutput("a_rs",    32'(bus.rs),          32'h1);
    checkOutput("a_rt",    32'(bus.rt),          32'h2);
    checkOutput("a_imm",   32'(bus.imm),         32'h0005);
    checkOutput("a_pc",    32'(bus.pc),          32'h0);

    bus.issue_ready = 1'b1;
    tick(1);
    bus.issue_ready = 1'b0;
    checkOutput("a_valid_drop", 32'(bus.issue_valid), 32'h0);
    bus.nextpc_valid = 1'b1;
    bus.nextpc_in    = 8'h05;
    tick(1);
    bus.nextpc_valid = 1'b0;
    checkOutput("a_retired", 32'(retired),       32'h1);
    checkOutput("b_req",     32'(bus.imem_req),  32'h1);
    checkOutput("b_addr",    32'(bus.imem_addr), 32'h05);

    // A nextpc strobe while fetching must be ignored.
    bus.nextpc_valid = 1'b1;
    bus.nextpc_in    = 8'h77;
    tick(1);
    bus.nextpc_valid = 1'b0;
    checkOutput("fetch_npc_addr",    32'(bus.imem_addr), 32'h05);
    checkOutput("fetch_npc_pc",      32'(bus.pc),        32'h05);
    checkOutput("fetch_npc_retired", 32'(retired),       32'h1);

    // Instruction B: R-type ADD, held by issue_ready=0 for five cycles.
    applyStimulus(1'b1, 32'h00221820);
    tick(1);
    applyStimulus(1'b0, 32'hFFFFFFFF);
    checkOutput("b_valid", 32'(bus.issue_valid), 32'h1);
    checkOutput("b_type",  32'(bus.instr_type),  32'h1);
    checkOutput("b_rs",    32'(bus.rs),          32'h1);
    checkOutput("b_rt",    32'(bus.rt),          32'h2);
    checkOutput("b_rd",    32'(bus.rd),          32'h3);
    checkOutput("b_shamt", 32'(bus.shamt),       32'h0);
    checkOutput("b_funct", 32'(bus.funct),       32'h20);
    checkOutput("b_pc",    32'(bus.pc),          32'h05);
    tick(5);
    checkOutput("b_hold_valid", 32'(bus.issue_valid), 32'h1);
    checkOutput("b_hold_type",  32'(bus.instr_type),  32'h1);
    checkOutput("b_hold_rd",    32'(bus.rd),          32'h3);
    checkOutput("b_hold_funct", 32'(bus.funct),       32'h20);
    checkOutput("b_hold_imm",   32'(bus.imm),         32'h1820);
    retire(8'h06);
    checkOutput("b_retired", 32'(retired),       32'h2);
    checkOutput("c_addr",    32'(bus.imem_addr), 32'h06);

    // Instruction C: J-type.
    applyStimulus(1'b1, 32'h08000010);
    tick(1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("c_type",   32'(bus.instr_type), 32'h2);
    checkOutput("c_opc",    32'(bus.opc),        32'h02);
    checkOutput("c_iindex", 32'(bus.iindex),     32'h0000010);
    checkOutput("c_pc",     32'(bus.pc),         32'h06);
    retire(8'h07);
    checkOutput("d_addr", 32'(bus.imem_addr), 32'h07);

    // Instruction D: illegal opcode; run drops before nextpc -> IDLE.
    applyStimulus(1'b1, 32'h40000000);
    tick(1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("d_type", 32'(bus.instr_type), 32'h3);
    checkOutput("d_opc",  32'(bus.opc),        32'h10);
    run = 1'b0;
    retire(8'h08);
    checkOutput("d_idle_req", 32'(bus.imem_req), 32'h0);
    checkOutput("d_retired",  32'(retired),      32'h4);
    tick(2);
    checkOutput("d_idle_hold", 32'(bus.imem_req), 32'h0);

    // Timeout: withhold ack, flag appears in the TIMEOUT-th fetch cycle.
    run = 1'b1;
    tick(1);
    checkOutput("to_req",  32'(bus.imem_req),  32'h1);
    checkOutput("to_addr", 32'(bus.imem_addr), 32'h08);
    tick(TIMEOUT - 2);
    checkOutput("to_err_before", 32'(fetch_err), 32'h0);
    tick(1);
    checkOutput("to_err_set",  32'(fetch_err),    32'h1);
    checkOutput("to_req_held", 32'(bus.imem_req), 32'h1);
    tick(3);
    checkOutput("to_err_sticky", 32'(fetch_err),     32'h1);
    checkOutput("to_addr_held",  32'(bus.imem_addr), 32'h08);
    applyStimulus(1'b1, 32'h2402FFFF);
    tick(1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("to_err_clear", 32'(fetch_err),       32'h0);
    checkOutput("to_valid",     32'(bus.issue_valid), 32'h1);
    checkOutput("to_imm",       32'(bus.imm),         32'hFFFF);
    checkOutput("to_rt",        32'(bus.rt),          32'h2);
    checkOutput("to_pc",        32'(bus.pc),          32'h08);
    retire(8'h09);
    checkOutput("e_addr",    32'(bus.imem_addr), 32'h09);
    checkOutput("e_retired", 32'(retired),       32'h5);

    // Asynchronous reset mid-fetch.
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_req",     32'(bus.imem_req), 32'h0);
    checkOutput("arst_pc",      32'(bus.pc),       32'h0);
    checkOutput("arst_retired", 32'(retired),      32'h0);
    checkOutput("arst_type",    32'(bus.instr_type), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    checkOutput("restart_req",  32'(bus.imem_req),  32'h1);
    checkOutput("restart_addr", 32'(bus.imem_addr), 32'h0);

    // Ack on the same edge the timeout would fire: ack wins.
    tick(TIMEOUT - 2);
    applyStimulus(1'b1, 32'h00000000);
    tick(1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("race_err",   32'(fetch_err),       32'h0);
    checkOutput("race_valid", 32'(bus.issue_valid), 32'h1);
    checkOutput("race_type",  32'(bus.instr_type),  32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFails);
    $finish;
  end

endmodule
